// File: rtl/dt1_id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures decoded controls and
// datapath values and presents them to execute, with stall, flush, valid, trap and retire-order tag.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   StallE, FlushE       : hazard-unit hold / bubble requests
//   ValidD, IllegalD     : decode-stage instruction valid / unsupported op
//   *D control fields    : RegWrite, ResultSrc, MemWrite, Jump, Branch,
//                          ALUControl, ALUASrc, ALUBSrc, LoadSize, PCTargetALUSrc
//   *D data/index fields : RD1, RD2, PC, PCPlus4, ImmExt, Rs1, Rs2, Rd, Instr
//   *E outputs           : registered copies of the above
//   ValidE, TrapE        : E-stage instruction valid / illegal
//   OrderE               : retire-order tag of the E-stage instruction
module dt1_id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 4,
    parameter int ORDER_W   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic                 IllegalD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic [1:0]           MemWriteD,
    input  logic                 JumpD,
    input  logic                 BranchD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [1:0]           ALUASrcD,
    input  logic                 ALUBSrcD,
    input  logic [2:0]           LoadSizeD,
    input  logic                 PCTargetALUSrcD,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      PCD,
    input  logic [XLEN-1:0]      PCPlus4D,
    input  logic [XLEN-1:0]      ImmExtD,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdD,
    input  logic [XLEN-1:0]      InstrD,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [1:0]           ALUASrcE,
    output logic                 ALUBSrcE,
    output logic [2:0]           LoadSizeE,
    output logic                 PCTargetALUSrcE,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [XLEN-1:0]      ImmExtE,
    output logic [4:0]           Rs1E,
    output logic [4:0]           Rs2E,
    output logic [4:0]           RdE,
    output logic [XLEN-1:0]      InstrE,
    output logic                 ValidE,
    output logic                 TrapE,
    output logic [ORDER_W-1:0]   OrderE
);

    logic [ORDER_W-1:0] order_cnt;

    logic hold;
    logic take;
    logic take_ctrl;

    logic                 reg_write_n;
    logic [1:0]           result_src_n;
    logic [1:0]           mem_write_n;
    logic                 jump_n;
    logic                 branch_n;
    logic [ALUCTRL_W-1:0] alu_control_n;
    logic [1:0]           alu_a_src_n;
    logic                 alu_b_src_n;
    logic [2:0]           load_size_n;
    logic                 pc_target_src_n;
    logic [XLEN-1:0]      rd1_n;
    logic [XLEN-1:0]      rd2_n;
    logic [XLEN-1:0]      pc_n;
    logic [XLEN-1:0]      pc_plus4_n;
    logic [XLEN-1:0]      imm_ext_n;
    logic [4:0]           rs1_n;
    logic [4:0]           rs2_n;
    logic [4:0]           rd_n;
    logic [XLEN-1:0]      instr_n;
    logic                 valid_n;
    logic                 trap_n;
    logic [ORDER_W-1:0]   order_n;
    logic [ORDER_W-1:0]   order_cnt_n;

    // Flush beats stall; an invalid D slot loads a bubble like a flush.
    always_comb begin
        hold      = StallE & ~FlushE;
        take      = ~FlushE & ~StallE & ValidD;
        take_ctrl = take & ~IllegalD;
    end

    always_comb begin
        reg_write_n     = 1'b0;
        result_src_n    = '0;
        mem_write_n     = '0;
        jump_n          = 1'b0;
        branch_n        = 1'b0;
        alu_control_n   = '0;
        alu_a_src_n     = '0;
        alu_b_src_n     = 1'b0;
        load_size_n     = '0;
        pc_target_src_n = 1'b0;
        rd1_n           = '0;
        rd2_n           = '0;
        pc_n            = '0;
        pc_plus4_n      = '0;
        imm_ext_n       = '0;
        rs1_n           = '0;
        rs2_n           = '0;
        rd_n            = '0;
        instr_n         = '0;
        valid_n         = 1'b0;
        trap_n          = 1'b0;
        order_n         = '0;
        order_cnt_n     = order_cnt;

        if (hold) begin
            reg_write_n     = RegWriteE;
            result_src_n    = ResultSrcE;
            mem_write_n     = MemWriteE;
            jump_n          = JumpE;
            branch_n        = BranchE;
            alu_control_n   = ALUControlE;
            alu_a_src_n     = ALUASrcE;
            alu_b_src_n     = ALUBSrcE;
            load_size_n     = LoadSizeE;
            pc_target_src_n = PCTargetALUSrcE;
            rd1_n           = RD1E;
            rd2_n           = RD2E;
            pc_n            = PCE;
            pc_plus4_n      = PCPlus4E;
            imm_ext_n       = ImmExtE;
            rs1_n           = Rs1E;
            rs2_n           = Rs2E;
            rd_n            = RdE;
            instr_n         = InstrE;
            valid_n         = ValidE;
            trap_n          = TrapE;
            order_n         = OrderE;
        end else if (take) begin
            rd1_n       = RD1D;
            rd2_n       = RD2D;
            pc_n        = PCD;
            pc_plus4_n  = PCPlus4D;
            imm_ext_n   = ImmExtD;
            rs1_n       = Rs1D;
            rs2_n       = Rs2D;
            rd_n        = RdD;
            instr_n     = InstrD;
            valid_n     = 1'b1;
            trap_n      = IllegalD;
            order_n     = order_cnt;
            order_cnt_n = order_cnt + 1'b1;
            // Controls are only sampled when legal, so X on an illegal
            // instruction's controls never reaches E.
            if (take_ctrl) begin
                reg_write_n     = RegWriteD;
                result_src_n    = ResultSrcD;
                mem_write_n     = MemWriteD;
                jump_n          = JumpD;
                branch_n        = BranchD;
                alu_control_n   = ALUControlD;
                alu_a_src_n     = ALUASrcD;
                alu_b_src_n     = ALUBSrcD;
                load_size_n     = LoadSizeD;
                pc_target_src_n = PCTargetALUSrcD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteE       <= 1'b0;
            ResultSrcE      <= '0;
            MemWriteE       <= '0;
            JumpE           <= 1'b0;
            BranchE         <= 1'b0;
            ALUControlE     <= '0;
            ALUASrcE        <= '0;
            ALUBSrcE        <= 1'b0;
            LoadSizeE       <= '0;
            PCTargetALUSrcE <= 1'b0;
            RD1E            <= '0;
            RD2E            <= '0;
            PCE             <= '0;
            PCPlus4E        <= '0;
            ImmExtE         <= '0;
            Rs1E            <= '0;
            Rs2E            <= '0;
            RdE             <= '0;
            InstrE          <= '0;
            ValidE          <= 1'b0;
            TrapE           <= 1'b0;
            OrderE          <= '0;
            order_cnt       <= '0;
        end else begin
            RegWriteE       <= reg_write_n;
            ResultSrcE      <= result_src_n;
            MemWriteE       <= mem_write_n;
            JumpE           <= jump_n;
            BranchE         <= branch_n;
            ALUControlE     <= alu_control_n;
            ALUASrcE        <= alu_a_src_n;
            ALUBSrcE        <= alu_b_src_n;
            LoadSizeE       <= load_size_n;
            PCTargetALUSrcE <= pc_target_src_n;
            RD1E            <= rd1_n;
            RD2E            <= rd2_n;
            PCE             <= pc_n;
            PCPlus4E        <= pc_plus4_n;
            ImmExtE         <= imm_ext_n;
            Rs1E            <= rs1_n;
            Rs2E            <= rs2_n;
            RdE             <= rd_n;
            InstrE          <= instr_n;
            ValidE          <= valid_n;
            TrapE           <= trap_n;
            OrderE          <= order_n;
            order_cnt       <= order_cnt_n;
        end
    end

endmodule

// File: tb/tb_dt1_id_ex_stage.sv
// Directed testbench for dt1_id_ex_stage: reset, ordering, stall, flush,
// illegal-trap and counter wrap (second instance with a 4-bit counter).
module tb_dt1_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallE, FlushE, ValidD, IllegalD;
    logic        RegWriteD, JumpD, BranchD, ALUBSrcD, PCTargetALUSrcD;
    logic [1:0]  ResultSrcD, MemWriteD, ALUASrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  LoadSizeD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, InstrD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE;
    logic [1:0]  ResultSrcE, MemWriteE, ALUASrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  LoadSizeE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, InstrE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, TrapE;
    logic [63:0] OrderE;

    logic        w_RegWriteE, w_JumpE, w_BranchE, w_ALUBSrcE, w_PCTargetALUSrcE;
    logic [1:0]  w_ResultSrcE, w_MemWriteE, w_ALUASrcE;
    logic [3:0]  w_ALUControlE;
    logic [2:0]  w_LoadSizeE;
    logic [31:0] w_RD1E, w_RD2E, w_PCE, w_PCPlus4E, w_ImmExtE, w_InstrE;
    logic [4:0]  w_Rs1E, w_Rs2E, w_RdE;
    logic        w_ValidE, w_TrapE;
    logic [3:0]  w_OrderE;

    int errors = 0;
    int checks = 0;

    logic [349:0] all_e;
    assign all_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                    ALUControlE, ALUASrcE, ALUBSrcE, LoadSizeE,
                    PCTargetALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
                    Rs1E, Rs2E, RdE, InstrE, ValidE, TrapE, OrderE};

    always #5 clk = ~clk;

    dt1_id_ex_stage dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .IllegalD(IllegalD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUASrcD(ALUASrcD),
        .ALUBSrcD(ALUBSrcD), .LoadSizeD(LoadSizeD),
        .PCTargetALUSrcD(PCTargetALUSrcD), .RD1D(RD1D), .RD2D(RD2D),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D),
        .Rs2D(Rs2D), .RdD(RdD), .InstrD(InstrD),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUASrcE(ALUASrcE),
        .ALUBSrcE(ALUBSrcE), .LoadSizeE(LoadSizeE),
        .PCTargetALUSrcE(PCTargetALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E),
        .Rs2E(Rs2E), .RdE(RdE), .InstrE(InstrE), .ValidE(ValidE),
        .TrapE(TrapE), .OrderE(OrderE)
    );

    dt1_id_ex_stage #(.ORDER_W(4)) dut_w (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .IllegalD(IllegalD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUASrcD(ALUASrcD),
        .ALUBSrcD(ALUBSrcD), .LoadSizeD(LoadSizeD),
        .PCTargetALUSrcD(PCTargetALUSrcD), .RD1D(RD1D), .RD2D(RD2D),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D),
        .Rs2D(Rs2D), .RdD(RdD), .InstrD(InstrD),
        .RegWriteE(w_RegWriteE), .ResultSrcE(w_ResultSrcE),
        .MemWriteE(w_MemWriteE), .JumpE(w_JumpE), .BranchE(w_BranchE),
        .ALUControlE(w_ALUControlE), .ALUASrcE(w_ALUASrcE),
        .ALUBSrcE(w_ALUBSrcE), .LoadSizeE(w_LoadSizeE),
        .PCTargetALUSrcE(w_PCTargetALUSrcE), .RD1E(w_RD1E), .RD2E(w_RD2E),
        .PCE(w_PCE), .PCPlus4E(w_PCPlus4E), .ImmExtE(w_ImmExtE),
        .Rs1E(w_Rs1E), .Rs2E(w_Rs2E), .RdE(w_RdE), .InstrE(w_InstrE),
        .ValidE(w_ValidE), .TrapE(w_TrapE), .OrderE(w_OrderE)
    );

    task automatic clear_d();
        StallE = 0; FlushE = 0; ValidD = 0; IllegalD = 0;
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0;
        BranchD = 0; ALUControlD = 0; ALUASrcD = 0; ALUBSrcD = 0;
        LoadSizeD = 0; PCTargetALUSrcD = 0;
        RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; InstrD = 0;
    endtask

    task automatic set_alu(input logic [31:0] pc, input logic [4:0] rd);
        clear_d();
        ValidD = 1; RegWriteD = 1; ALUControlD = 4'h2;
        PCD = pc; PCPlus4D = pc + 4; RdD = rd;
        RD1D = 32'h11; RD2D = 32'h22; InstrD = 32'h00208033;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clear_d();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_d();
        reset = 1; ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b11;
        MemWriteD = 2'b11; JumpD = 1; BranchD = 1; ALUControlD = 4'hF;
        ALUASrcD = 2'b11; ALUBSrcD = 1; LoadSizeD = 3'b111;
        PCTargetALUSrcD = 1; RD1D = 32'hA5A5A5A5; RD2D = 32'h5A5A5A5A;
        PCD = 32'h1234; PCPlus4D = 32'h1238; ImmExtD = 32'hFFFF0000;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; InstrD = 32'hDEADBEEF;
        step();
        checks++;
        if (all_e !== '0) begin
            errors++;
            $display("FAIL reset_c1 got %h want 0", all_e);
        end
        StallE = 1; FlushE = 1;
        step();
        checks++;
        if (all_e !== '0) begin
            errors++;
            $display("FAIL reset_c2_stall_flush got %h want 0", all_e);
        end
        reset = 0;
        clear_d();
        ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; ALUBSrcD = 1;
        LoadSizeD = 3'b000; RdD = 5'd5; PCD = 32'h100;
        step();
        checks++;
        if ({RegWriteE, ResultSrcE, ALUBSrcE, RdE, PCE, ValidE, TrapE}
            !== {1'b1, 2'b01, 1'b1, 5'd5, 32'h100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL lw_fields got rw=%0d rs=%0d bs=%0d rd=%0d pc=%h v=%0d t=%0d want 1 1 1 5 100 1 0",
                     RegWriteE, ResultSrcE, ALUBSrcE, RdE, PCE, ValidE, TrapE);
        end
        checks++;
        if (OrderE !== 64'd0) begin
            errors++;
            $display("FAIL lw_order got %0d want 0", OrderE);
        end
    endtask

    task automatic test_order();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            set_alu(32'h400 + 32'(i * 4), 5'(i + 1));
            step();
            checks++;
            if (OrderE !== 64'(i) || ValidE !== 1'b1) begin
                errors++;
                $display("FAIL order_seq%0d got ord=%0d v=%0d want %0d 1", i, OrderE, ValidE, i);
            end
        end
        clear_d();
        step();
        checks++;
        if (ValidE !== 1'b0 || OrderE !== 64'd0 || RdE !== 5'd0) begin
            errors++;
            $display("FAIL order_bubble got v=%0d ord=%0d rd=%0d want 0 0 0", ValidE, OrderE, RdE);
        end
        set_alu(32'h40C, 5'd9);
        step();
        checks++;
        if (OrderE !== 64'd3 || ValidE !== 1'b1) begin
            errors++;
            $display("FAIL order_after_bubble got ord=%0d v=%0d want 3 1", OrderE, ValidE);
        end
    endtask

    task automatic test_stall();
        clear_d();
        ValidD = 1; MemWriteD = 2'b01; ALUBSrcD = 1; PCD = 32'h200;
        Rs1D = 5'd2; Rs2D = 5'd7;
        step();
        checks++;
        if (MemWriteE !== 2'b01 || PCE !== 32'h200 || OrderE !== 64'd4) begin
            errors++;
            $display("FAIL sw_load got mw=%0d pc=%h ord=%0d want 1 200 4", MemWriteE, PCE, OrderE);
        end
        clear_d();
        StallE = 1; ValidD = 1; BranchD = 1; PCD = 32'h204;
        ALUControlD = 4'h1; IllegalD = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (MemWriteE !== 2'b01 || PCE !== 32'h200 || BranchE !== 1'b0
                || OrderE !== 64'd4 || TrapE !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got mw=%0d pc=%h br=%0d ord=%0d t=%0d want 1 200 0 4 0",
                         i, MemWriteE, PCE, BranchE, OrderE, TrapE);
            end
        end
        StallE = 0; IllegalD = 0;
        step();
        checks++;
        if (BranchE !== 1'b1 || PCE !== 32'h204 || OrderE !== 64'd5
            || MemWriteE !== 2'b00) begin
            errors++;
            $display("FAIL beq_release got br=%0d pc=%h ord=%0d mw=%0d want 1 204 5 0",
                     BranchE, PCE, OrderE, MemWriteE);
        end
    endtask

    task automatic test_flush();
        clear_d();
        StallE = 1; FlushE = 1; ValidD = 1; JumpD = 1; RegWriteD = 1;
        ResultSrcD = 2'b10; RdD = 5'd1; PCD = 32'h208;
        step();
        checks++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || JumpE !== 1'b0
            || RdE !== 5'd0 || PCE !== 32'd0 || OrderE !== 64'd0) begin
            errors++;
            $display("FAIL flush_bubble got v=%0d rw=%0d j=%0d rd=%0d pc=%h ord=%0d want all 0",
                     ValidE, RegWriteE, JumpE, RdE, PCE, OrderE);
        end
        set_alu(32'h300 - 4, 5'd4);
        step();
        checks++;
        if (OrderE !== 64'd6) begin
            errors++;
            $display("FAIL flush_counter_held got %0d want 6", OrderE);
        end
    endtask

    task automatic test_illegal();
        clear_d();
        ValidD = 1; IllegalD = 1;
        RegWriteD = 'x; ResultSrcD = 'x; MemWriteD = 'x; JumpD = 'x;
        BranchD = 'x; ALUControlD = 'x; ALUASrcD = 'x; ALUBSrcD = 'x;
        LoadSizeD = 'x; PCTargetALUSrcD = 'x;
        InstrD = 32'hFFFFFFFF; PCD = 32'h300; RdD = 5'd12; RD1D = 32'h77;
        step();
        checks++;
        if (TrapE !== 1'b1 || ValidE !== 1'b1 || InstrE !== 32'hFFFFFFFF
            || PCE !== 32'h300 || RdE !== 5'd12 || RD1E !== 32'h77) begin
            errors++;
            $display("FAIL illegal_copy got t=%0d v=%0d ins=%h pc=%h rd=%0d rd1=%h want 1 1 ffffffff 300 12 77",
                     TrapE, ValidE, InstrE, PCE, RdE, RD1E);
        end
        checks++;
        if ({RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
             ALUASrcE, ALUBSrcE, LoadSizeE, PCTargetALUSrcE} !== 18'd0) begin
            errors++;
            $display("FAIL illegal_ctrl got rw=%b rs=%b mw=%b j=%b br=%b alu=%b as=%b bs=%b ls=%b pt=%b want 0",
                     RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                     ALUASrcE, ALUBSrcE, LoadSizeE, PCTargetALUSrcE);
        end
        checks++;
        if (OrderE !== 64'd7) begin
            errors++;
            $display("FAIL illegal_order got %0d want 7", OrderE);
        end
        set_alu(32'h304, 5'd6);
        step();
        checks++;
        if (OrderE !== 64'd8 || TrapE !== 1'b0 || RegWriteE !== 1'b1) begin
            errors++;
            $display("FAIL after_illegal got ord=%0d t=%0d rw=%0d want 8 0 1", OrderE, TrapE, RegWriteE);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 15; i++) begin
            set_alu(32'h500 + 32'(i * 4), 5'd3);
            step();
        end
        set_alu(32'h53C, 5'd3);
        step();
        checks++;
        if (w_OrderE !== 4'hF || w_ValidE !== 1'b1) begin
            errors++;
            $display("FAIL wrap_allones got %h v=%0d want f 1", w_OrderE, w_ValidE);
        end
        set_alu(32'h540, 5'd3);
        step();
        checks++;
        if (w_OrderE !== 4'h0 || w_ValidE !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero got %h v=%0d want 0 1", w_OrderE, w_ValidE);
        end
        checks++;
        if (OrderE !== 64'd16) begin
            errors++;
            $display("FAIL wide_no_wrap got %0d want 16", OrderE);
        end
        set_alu(32'h544, 5'd3);
        step();
        checks++;
        if (w_OrderE !== 4'h1) begin
            errors++;
            $display("FAIL wrap_continue got %h want 1", w_OrderE);
        end
    endtask

    initial begin
        clear_d();
        reset = 1;
        test_reset();
        test_order();
        test_stall();
        test_flush();
        test_illegal();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dt1_id_ex_stage.md
Name: dt1_id_ex_stage

Overview:
ID/EX pipeline register for the RV32I core. It sits directly downstream of the main/ALU decoders: it captures the decoded control bundle and the decode-stage datapath values and presents them to the execute stage. It supports hazard-unit stall and flush, carries a per-instruction valid bit and a 64-bit retire-order tag, and converts an illegal-opcode indication into a trap-marked bubble with all side-effecting controls forced to zero.

Parameters:
XLEN, 32, datapath width (PC, register operands, immediate, instruction word)
ALUCTRL_W, 4, width of the ALU control field from the ALU decoder
ORDER_W, 64, width of the retire-order counter

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
StallE  input  1  hold all E-stage contents (hazard unit)
FlushE  input  1  load a bubble into E (branch taken / load-use)
ValidD  input  1  decode stage holds a real instruction
IllegalD  input  1  decoder found an unsupported op/funct3
RegWriteD  input  1  control
ResultSrcD  input  2  control
MemWriteD  input  2  control (00 none, 01 sw, 10 sh, 11 sb)
JumpD  input  1  control
BranchD  input  1  control
ALUControlD  input  ALUCTRL_W  control
ALUASrcD  input  2  control
ALUBSrcD  input  1  control
LoadSizeD  input  3  control
PCTargetALUSrcD  input  1  control
RD1D, RD2D  input  XLEN each  register-file read data
PCD, PCPlus4D, ImmExtD  input  XLEN each  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  input  5 each  register indices
InstrD  input  XLEN  raw instruction word
(E-suffixed outputs for each of the above control, data and index fields, same widths)
ValidE  output  1  E stage holds a real instruction
TrapE  output  1  E-stage instruction is illegal
OrderE  output  ORDER_W  retire-order tag of E-stage instruction

Behaviour:
- All registers update only on rising clk. Update priority: reset > FlushE > StallE > normal load.
- reset=1: every output 0 (controls, data, indices, InstrE, ValidE, TrapE, OrderE); internal order counter cleared to 0. Reset asserted mid-stall or mid-flush overrides both.
- FlushE=1 (reset=0): bubble. All controls 0, ValidE=0, TrapE=0, RdE=0, all data fields 0, OrderE 0. Counter does not advance. FlushE together with StallE: flush wins.
- StallE=1, FlushE=0: every E register and the counter hold their value. Inputs ignored, including IllegalD.
- Normal load (reset=0, FlushE=0, StallE=0):
  - ValidD=0: treated as a bubble, identical to flush. Counter holds.
  - ValidD=1, IllegalD=0: all D fields copied to E. ValidE=1, TrapE=0, OrderE=counter, then counter+1.
  - ValidD=1, IllegalD=1: RegWriteE=0, MemWriteE=00, BranchE=0, JumpE=0, ResultSrcE=00, ALUControlE/ALUASrcE/ALUBSrcE/LoadSizeE/PCTargetALUSrcE=0, regardless of input values, including X. Data, indices, PCE and InstrE are copied. ValidE=1, TrapE=1, OrderE=counter, then counter+1.
- Counter increments modulo 2^ORDER_W and wraps from all-ones to 0 with no side effect.
- Latency: one cycle from D input to E output. No combinational path from any input to any output.
- With ValidD=1 and IllegalD=0, E outputs never carry X when D inputs are known. With IllegalD=1, controls are defined even when D controls are X.

Test Plan:
- Reset: drive reset=1 for 2 cycles with all D inputs nonzero -> all E outputs 0 and OrderE=0. Release, then load lw (RegWriteD=1, ResultSrcD=01, ALUBSrcD=1, LoadSizeD=000, RdD=5, PCD=0x100) -> next cycle RegWriteE=1, ResultSrcE=01, RdE=5, PCE=0x100, ValidE=1, OrderE=0.
- Order sequence: 3 back-to-back valid instructions -> OrderE=0,1,2. Insert ValidD=0 for 1 cycle, then 1 valid instruction -> ValidE=0 for that cycle, and the next instruction gets OrderE=3.
- Stall: load sw (MemWriteD=01, PCD=0x200), assert StallE for 3 cycles while D changes to beq -> E holds MemWriteE=01, PCE=0x200 for all 3 cycles. Deassert -> beq appears with OrderE advanced by exactly 1.
- Flush vs stall: assert StallE=1 and FlushE=1 together with jal on D -> next cycle ValidE=0, RegWriteE=0, JumpE=0, RdE=0, and the counter is unchanged.
- Illegal: ValidD=1, IllegalD=1, all D controls X, InstrD=0xFFFFFFFF, PCD=0x300 -> TrapE=1, ValidE=1, RegWriteE=0, MemWriteE=00, BranchE=0, JumpE=0, InstrE=0xFFFFFFFF, PCE=0x300, and the counter increments.
- Wrap: preload the counter to 0xFFFF_FFFF_FFFF_FFFF (force or ORDER_W=4 build) and load 2 valid instructions -> OrderE=all-ones, then 0.
